// File: rtl/std_alu_arb_pkg.sv
// Shared types and sizing helpers for the std_alu_arbiter slice.
//   op_e    : requester opcode encoding
//   state_e : sequencer state encoding
//   cnt_width(): width of the BUSY-cycle down-counter for a given mul latency
package std_alu_arb_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_LT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned MUL_CYCLES_DEFAULT = 3;
  localparam int unsigned CNT_W_DEFAULT      = $clog2(MUL_CYCLES_DEFAULT + 1);

  // Counter must hold MUL_CYCLES-1; sized as clog2(MUL_CYCLES+1) for headroom.
  function automatic int unsigned cnt_width(input int unsigned mul_cycles);
    return $clog2(mul_cycles + 1);
  endfunction

endpackage

// File: rtl/std_alu_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   gnt_c : one-hot grant of the first asserted request at or after ptr (wrapping)
//   idx_c : index of gnt_c
//   any_c : at least one request asserted
module std_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  // Scan NUM_REQ slots starting at ptr; first hit wins.
  always_comb begin
    logic [IDX_W-1:0] k;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any_c && req[k]) begin
        any_c    = 1'b1;
        idx_c    = k;
        gnt_c[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/std_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/sub/mul/lt datapath between
// NUM_REQ requesters.
//   clk, reset        : clock, async active-high reset
//   valid             : global enable for new grants
//   req_valid/op/left/right : per-requester request, opcode and operands (packed)
//   grant             : one-hot owner during BUSY and DONE
//   resp_valid        : one-hot one-cycle completion pulse (DONE)
//   resp_out          : registered result, held until next completion
//   resp_out_read_out : high whenever resp_valid is non-zero
//   ready             : high while IDLE
module std_alu_arbiter
  import std_alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_left,
  input  logic [WIDTH*NUM_REQ-1:0] req_right,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_out,
  output logic                     resp_out_read_out,
  output logic                     ready
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MUL_CYCLES);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     left_q, left_d;
  logic [WIDTH-1:0]     right_q, right_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]     resp_out_q, resp_out_d;
  logic                 rd_out_q, rd_out_d;
  logic                 ready_q, ready_d;

  logic [NUM_REQ-1:0]   pick_req_c;
  logic [NUM_REQ-1:0]   pick_gnt_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 pick_any_c;
  logic [1:0]           sel_op_c;
  logic [WIDTH-1:0]     sel_left_c;
  logic [WIDTH-1:0]     sel_right_c;
  logic [WIDTH-1:0]     alu_c;

  // valid gates new grants only; in-flight work is unaffected.
  assign pick_req_c = req_valid & {NUM_REQ{valid}};

  std_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (pick_req_c),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Mux out the picked requester's opcode and operands.
  always_comb begin
    sel_op_c    = '0;
    sel_left_c  = '0;
    sel_right_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_c == IDX_W'(i)) begin
        sel_op_c    = req_op[2*i +: 2];
        sel_left_c  = req_left[WIDTH*i +: WIDTH];
        sel_right_c = req_right[WIDTH*i +: WIDTH];
      end
    end
  end

  // Shared datapath, fed only from the latched operands.
  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_ADD:  alu_c = left_q + right_q;
      OP_SUB:  alu_c = left_q - right_q;
      OP_MUL:  alu_c = left_q * right_q;
      OP_LT:   alu_c = {{(WIDTH-1){1'b0}}, (left_q < right_q)};
      default: alu_c = '0;
    endcase
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    op_d         = op_q;
    left_d       = left_q;
    right_d      = right_q;
    cnt_d        = cnt_q;
    resp_valid_d = '0;
    resp_out_d   = resp_out_q;
    rd_out_d     = 1'b0;
    ready_d      = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          gidx_d  = pick_idx_c;
          grant_d = pick_gnt_c;
          op_d    = op_e'(sel_op_c);
          left_d  = sel_left_c;
          right_d = sel_right_c;
          cnt_d   = (op_e'(sel_op_c) == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
          ready_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          resp_out_d   = alu_c;
          resp_valid_d = grant_q;
          rd_out_d     = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Served requester drops to lowest priority.
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
        grant_d = '0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      grant_q      <= '0;
      op_q         <= OP_ADD;
      left_q       <= '0;
      right_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_out_q   <= '0;
      rd_out_q     <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      left_q       <= left_d;
      right_q      <= right_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_out_q   <= resp_out_d;
      rd_out_q     <= rd_out_d;
      ready_q      <= ready_d;
    end
  end

  assign grant             = grant_q;
  assign resp_valid        = resp_valid_q;
  assign resp_out          = resp_out_q;
  assign resp_out_read_out = rd_out_q;
  assign ready             = ready_q;

endmodule

// File: tb/tb_std_alu_arbiter.sv
// Self-checking bench for std_alu_arbiter: directed scenarios plus random
// traffic, all outputs compared every cycle against a transaction-schedule model.
module tb_std_alu_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MC = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid;
  logic [N-1:0]      req_valid;
  logic [2*N-1:0]    req_op;
  logic [W*N-1:0]    req_left;
  logic [W*N-1:0]    req_right;
  logic [N-1:0]      grant;
  logic [N-1:0]      resp_valid;
  logic [W-1:0]      resp_out;
  logic              rd_out;
  logic              ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: last grant index, issue cycle, completion cycle, results, rr pointer.
  int              m_ptr, m_g, m_iss, m_dn;
  longint unsigned m_pend, m_res;

  always #5 clk = ~clk;

  std_alu_arbiter #(.WIDTH(W), .NUM_REQ(N), .MUL_CYCLES(MC)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid             (valid),
    .req_valid         (req_valid),
    .req_op            (req_op),
    .req_left          (req_left),
    .req_right         (req_right),
    .grant             (grant),
    .resp_valid        (resp_valid),
    .resp_out          (resp_out),
    .resp_out_read_out (rd_out),
    .ready             (ready)
  );

  function automatic longint unsigned ref_alu(input int op, input longint unsigned l,
                                              input longint unsigned r);
    longint unsigned m;
    m = 64'hFFFF_FFFF;
    case (op)
      0:       return (l + r) & m;
      1:       return (l + (m + 1) - r) & m;
      2:       return (l * r) & m;
      default: return (l < r) ? 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic int ref_pick(input logic [N-1:0] rq, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (rq[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic bit busy_at(input int c);
    return (c > m_iss) && (c <= m_dn);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    if (cyc == m_dn) begin
      m_res = m_pend;
      m_ptr = (m_g + 1) % N;
    end
    chk("grant", grant, busy_at(cyc) ? onehot(m_g) : {N{1'b0}});
    chk("resp_valid", resp_valid, (cyc == m_dn) ? onehot(m_g) : {N{1'b0}});
    chk("read_out", rd_out, cyc == m_dn);
    chk("ready", ready, !busy_at(cyc));
    chk("resp_out", resp_out, m_res);
    if (cyc == m_dn) req_valid[m_g] = 1'b0;
  endtask

  // Model reacts to the inputs held during the cycle that is ending.
  task automatic decide();
    int op;
    if (!reset && valid && !busy_at(cyc) && (|req_valid)) begin
      m_g    = ref_pick(req_valid, m_ptr);
      op     = int'(req_op[2*m_g +: 2]);
      m_iss  = cyc;
      m_dn   = cyc + ((op == 2) ? MC : 1) + 1;
      m_pend = ref_alu(op, 64'(req_left[W*m_g +: W]), 64'(req_right[W*m_g +: W]));
    end
  endtask

  task automatic tick();
    decide();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic model_reset();
    m_iss = -100;
    m_dn  = -100;
    m_ptr = 0;
    m_g   = 0;
    m_res = 0;
    m_pend = 0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases after one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_cycle();
    chk("rst_grant", grant, 0);
    chk("rst_resp_out", resp_out, 0);
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input int op, input logic [W-1:0] l, input logic [W-1:0] r);
    req_op[2*i +: 2]    = 2'(op);
    req_left[W*i +: W]  = l;
    req_right[W*i +: W] = r;
    req_valid[i]        = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    return ($urandom % 4 == 0) ? W'($urandom % 16) : W'($urandom);
  endfunction

  task automatic serve(input int i, input int op, input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic [W-1:0] exp, input int lat);
    int t0;
    bit got;
    set_req(i, op, l, r);
    t0  = cyc;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (resp_valid != 0) got = 1'b1;
    end
    chk("serve_timeout", got, 1);
    if (got) begin
      chk("serve_latency", cyc - t0, lat);
      chk("serve_result", resp_out, exp);
      chk("serve_owner", resp_valid, onehot(i));
    end
    tick();
    chk("serve_ready_after", ready, 1);
  endtask

  initial begin
    int order[$];
    int when[$];
    int first_idx;
    int nresp;
    logic [W-1:0] a, b;

    reset     = 1'b1;
    valid     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_left  = '0;
    req_right = '0;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    chk("reset_ready", ready, 1);
    reset = 1'b0;
    tick();

    // Single add, mul truncation, wrap-around sub, lt both ways.
    serve(0, 0, 32'd5, 32'd7, 32'd12, 2);
    serve(2, 2, 32'h0001_0000, 32'h0001_0000, 32'd0, MC + 1);
    serve(1, 1, 32'd3, 32'd5, 32'hFFFF_FFFE, 2);
    serve(3, 3, 32'd3, 32'd5, 32'd1, 2);
    serve(3, 3, 32'd5, 32'd3, 32'd0, 2);
    serve(2, 2, 32'd1234, 32'd1000, 32'd1234000, MC + 1);

    // Gating: requests ignored while valid is low.
    valid = 1'b0;
    set_req(0, 0, 32'd100, 32'd23);
    repeat (5) tick();
    chk("gate_grant", grant, 0);
    chk("gate_ready", ready, 1);
    valid = 1'b1;
    tick();
    chk("gate_release_grant", grant, 4'b0001);
    for (int k = 0; k < 10 && resp_valid == 0; k++) tick();
    chk("gate_result", resp_out, 32'd123);
    tick();

    // Contention: all requesters held; expect 0,1,2,3,0 every 3 cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 0, rnd_operand(), rnd_operand());
    for (int k = 0; k < 15; k++) begin
      tick();
      if (resp_valid != 0) begin
        for (int i = 0; i < N; i++) if (resp_valid[i]) order.push_back(i);
        when.push_back(cyc);
      end
      for (int i = 0; i < N; i++) if (!req_valid[i]) set_req(i, 0, rnd_operand(), rnd_operand());
    end
    chk("rr_count", 64'(order.size() >= 5), 1);
    if (order.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", order[k], k % N);
      for (int k = 1; k < 5; k++) chk("rr_interval", when[k] - when[k-1], 3);
    end
    req_valid = '0;
    repeat (6) tick();

    // Reset in the middle of a mul discards it and clears the rr pointer.
    serve(2, 0, 32'd1, 32'd2, 32'd3, 2);
    set_req(2, 2, 32'd77, 32'd11);
    tick();
    tick();
    chk("pre_rst_grant", grant, 4'b0100);
    req_valid = '0;
    do_reset();
    chk("rst_resp_valid", resp_valid, 0);
    repeat (3) tick();
    set_req(1, 0, 32'd10, 32'd20);
    set_req(3, 0, 32'd30, 32'd40);
    first_idx = -1;
    nresp = 0;
    for (int k = 0; k < 20 && nresp < 2; k++) begin
      tick();
      if (resp_valid != 0) begin
        if (first_idx < 0) first_idx = resp_valid[1] ? 1 : (resp_valid[3] ? 3 : 9);
        nresp++;
      end
    end
    chk("post_rst_first", first_idx, 1);
    chk("post_rst_both", nresp, 2);
    tick();
    a = rnd_operand();
    b = rnd_operand();
    serve(3, 0, a, b, W'(ref_alu(0, 64'(a), 64'(b))), 2);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      valid = ($urandom % 8) != 0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 4 == 0))
          set_req(i, int'($urandom % 4), rnd_operand(), rnd_operand());
      end
      tick();
    end
    valid = 1'b1;
    req_valid = '0;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
